// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic operand feeder.
//   state_t / St*  : feeder FSM state encoding
//   Def*           : default matrix dimensions
//   flush_len()    : zero beats needed to drain the array skew, max(M,L)-1
//   a_depth()      : A buffer entries, M*N
//   b_depth()      : B buffer entries, N*L
package systolic_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle     = 3'd0;
  localparam state_t StWaitRdy  = 3'd1;
  localparam state_t StStream   = 3'd2;
  localparam state_t StFlush    = 3'd3;
  localparam state_t StWaitDone = 3'd4;

  localparam int unsigned DefM = 3;
  localparam int unsigned DefN = 3;
  localparam int unsigned DefL = 3;

  function automatic int flush_len(input int m, input int l);
    return ((m > l) ? m : l) - 1;
  endfunction

  function automatic int a_depth(input int m, input int n);
    return m * n;
  endfunction

  function automatic int b_depth(input int n, input int l);
    return n * l;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Operand stream between the feeder and the systolic array.
//   array_ready : array -> feeder, array idle/ready
//   valid       : feeder -> array, beat present
//   left        : feeder -> array, Mritx_M slices of WIDTH_left (A column k)
//   up          : feeder -> array, Mritx_L slices of WIDTH_up (B row k)
// Modports: master = feeder side, slave = array side.
interface systolic_feeder_if
  import systolic_pkg::*;
#(
  parameter int WIDTH_left = 8,
  parameter int WIDTH_up   = 8,
  parameter int Mritx_M    = DefM,
  parameter int Mritx_L    = DefL
) ();

  logic                          array_ready;
  logic                          valid;
  logic [Mritx_M*WIDTH_left-1:0] left;
  logic [Mritx_L*WIDTH_up-1:0]   up;

  modport master (
    input  array_ready,
    output valid,
    output left,
    output up
  );

  modport slave (
    output array_ready,
    input  valid,
    input  left,
    input  up
  );

endinterface

// File: rtl/feeder_bank.sv
// Rows x Cols register file of Width-bit elements, flat row-major addressing.
//   clk     : clock
//   wr_en   : write strobe (caller gates range and busy)
//   wr_addr : flat index row*Cols+col
//   wr_data : element to store
//   rd_sel  : column (ReadCol=1) or row (ReadCol=0) to present
//   rd_data : combinational slice, slice s = element s of the selected column/row
// Contents have no reset; they persist until overwritten.
module feeder_bank #(
  parameter int Rows  = 3,
  parameter int Cols  = 3,
  parameter int Width = 8,
  parameter int AddrW = 10,
  parameter bit ReadCol = 1'b1,
  localparam int SliceLen = ReadCol ? Rows : Cols
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [AddrW-1:0]          wr_addr,
  input  logic [Width-1:0]          wr_data,
  input  logic [AddrW-1:0]          rd_sel,
  output logic [SliceLen*Width-1:0] rd_data
);

  localparam int Depth = Rows * Cols;

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    for (int e = 0; e < Depth; e++) begin
      if (wr_en && int'(wr_addr) == e) begin
        mem_q[e] <= wr_data;
      end
    end
  end

  // Address decode by comparison keeps every array select constant.
  always_comb begin
    rd_data = '0;
    for (int s = 0; s < SliceLen; s++) begin
      for (int e = 0; e < Depth; e++) begin
        if (e == (ReadCol ? s * Cols + int'(rd_sel) : int'(rd_sel) * Cols + s)) begin
          rd_data[s*Width +: Width] = mem_q[e];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the systolic matrix multiplier. Buffers A (MxN) and
// B (NxL), then streams N unskewed beats (column k of A on left, row k of B
// on up) followed by max(M,L)-1 zero beats to drain the array's skew.
//   clk, rst          : clock, synchronous active-high reset
//   a_wr_en/addr/data : A element write, addr = i*N+k (IDLE only)
//   b_wr_en/addr/data : B element write, addr = k*L+j (IDLE only)
//   start             : request one pass (IDLE only)
//   busy              : pass in progress
//   done              : one-cycle pulse as busy falls
//   arr               : stream to the array (array_ready, valid, left, up)
//   wr_err            : sticky bad-write flag, only with SYSTOLIC_FEEDER_WR_ERR_EN
// All outputs are registered. Buffers survive rst.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH_left      = 8,
  parameter int WIDTH_up        = 8,
  parameter int Mritx_M         = DefM,
  parameter int Mritx_N         = DefN,
  parameter int Mritx_L         = DefL,
  parameter int Mritx_LOG2_size = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_wr_en,
  input  logic [Mritx_LOG2_size-1:0] a_wr_addr,
  input  logic [WIDTH_left-1:0]      a_wr_data,
  input  logic                       b_wr_en,
  input  logic [Mritx_LOG2_size-1:0] b_wr_addr,
  input  logic [WIDTH_up-1:0]        b_wr_data,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
`ifdef SYSTOLIC_FEEDER_WR_ERR_EN
  output logic                       wr_err,
`endif
  systolic_feeder_if.master          arr
);

  localparam int CW       = Mritx_LOG2_size;
  localparam int ADepth   = a_depth(Mritx_M, Mritx_N);
  localparam int BDepth   = b_depth(Mritx_N, Mritx_L);
  localparam int FlushLen = flush_len(Mritx_M, Mritx_L);
  localparam int LW       = Mritx_M * WIDTH_left;
  localparam int UW       = Mritx_L * WIDTH_up;

  state_t          state_q, state_d;
  logic [CW-1:0]   k_q, k_d;
  logic [CW-1:0]   fl_q, fl_d;
  logic            seen_low_q, seen_low_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [LW-1:0]   left_q, left_d;
  logic [UW-1:0]   up_q, up_d;

  logic            idle;
  logic            a_in_range, b_in_range;
  logic [CW-1:0]   rd_k;
  logic [LW-1:0]   a_col;
  logic [UW-1:0]   b_row;

  assign idle       = (state_q == StIdle);
  assign a_in_range = int'(a_wr_addr) < ADepth;
  assign b_in_range = int'(b_wr_addr) < BDepth;
  // k reaches N on the last STREAM cycle; keep the read select in range.
  assign rd_k       = (int'(k_q) < Mritx_N) ? k_q : '0;

  feeder_bank #(
    .Rows    (Mritx_M),
    .Cols    (Mritx_N),
    .Width   (WIDTH_left),
    .AddrW   (CW),
    .ReadCol (1'b1)
  ) u_a_bank (
    .clk     (clk),
    .wr_en   (a_wr_en && idle && a_in_range),
    .wr_addr (a_wr_addr),
    .wr_data (a_wr_data),
    .rd_sel  (rd_k),
    .rd_data (a_col)
  );

  feeder_bank #(
    .Rows    (Mritx_N),
    .Cols    (Mritx_L),
    .Width   (WIDTH_up),
    .AddrW   (CW),
    .ReadCol (1'b0)
  ) u_b_bank (
    .clk     (clk),
    .wr_en   (b_wr_en && idle && b_in_range),
    .wr_addr (b_wr_addr),
    .wr_data (b_wr_data),
    .rd_sel  (rd_k),
    .rd_data (b_row)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    fl_d       = fl_q;
    seen_low_d = seen_low_q;
    valid_d    = 1'b0;
    left_d     = '0;
    up_d       = '0;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWaitRdy;
          k_d     = '0;
        end
      end
      StWaitRdy: begin
        if (arr.array_ready) begin
          state_d = StStream;
          valid_d = 1'b1;
          left_d  = a_col;
          up_d    = b_row;
          k_d     = k_q + 1'b1;
        end
      end
      StStream: begin
        // k_q is the next beat to emit; the current beat is already on the outputs.
        if (int'(k_q) < Mritx_N) begin
          valid_d = 1'b1;
          left_d  = a_col;
          up_d    = b_row;
          k_d     = k_q + 1'b1;
        end else if (FlushLen > 0) begin
          state_d = StFlush;
          valid_d = 1'b1;
          fl_d    = CW'(1);
        end else begin
          state_d    = StWaitDone;
          seen_low_d = 1'b0;
        end
      end
      StFlush: begin
        if (int'(fl_q) < FlushLen) begin
          valid_d = 1'b1;
          fl_d    = fl_q + 1'b1;
        end else begin
          state_d    = StWaitDone;
          seen_low_d = 1'b0;
        end
      end
      StWaitDone: begin
        // The array signals completion by dropping ready and raising it again.
        if (!arr.array_ready) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      fl_q       <= '0;
      seen_low_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      left_q     <= '0;
      up_q       <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      fl_q       <= fl_d;
      seen_low_q <= seen_low_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      left_q     <= left_d;
      up_q       <= up_d;
    end
  end

`ifdef SYSTOLIC_FEEDER_WR_ERR_EN
  logic wr_err_q, wr_err_d;
  logic offend;

  assign offend = (a_wr_en && (!idle || !a_in_range)) ||
                  (b_wr_en && (!idle || !b_in_range));

  // A bad write in the same cycle as an accepted start still flags.
  always_comb begin
    wr_err_d = wr_err_q;
    if (idle && start) wr_err_d = 1'b0;
    if (offend) wr_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wr_err_q <= 1'b0;
    else     wr_err_q <= wr_err_d;
  end

  assign wr_err = wr_err_q;
`endif

  assign arr.valid = valid_q;
  assign arr.left  = left_q;
  assign arr.up    = up_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: dut0 is M=N=L=3, dut1 is M=2, N=4, L=1.
// A queue-of-beats model predicts every output each cycle; literal checks pin
// the model on hand-computed beats.
module tb_systolic_feeder;

  localparam int PhIdle = 0, PhWaitRdy = 1, PhStream = 2, PhWaitDone = 3;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    [2];
  logic       a_en   [2];
  logic [9:0] a_addr [2];
  logic [7:0] a_data [2];
  logic       b_en   [2];
  logic [9:0] b_addr [2];
  logic [7:0] b_data [2];
  logic       start  [2];
  logic       rdy    [2];

  logic        busy0, busy1, done0, done1;
  logic        obs_busy  [2];
  logic        obs_done  [2];
  logic        obs_valid [2];
  logic [31:0] obs_left  [2];
  logic [31:0] obs_up    [2];
`ifdef SYSTOLIC_FEEDER_WR_ERR_EN
  logic        err0, err1;
  logic        obs_err   [2];
  assign obs_err[0] = err0;
  assign obs_err[1] = err1;
`endif

  systolic_feeder_if #(.WIDTH_left(8), .WIDTH_up(8), .Mritx_M(3), .Mritx_L(3)) if0 ();
  systolic_feeder_if #(.WIDTH_left(8), .WIDTH_up(8), .Mritx_M(2), .Mritx_L(1)) if1 ();

  assign if0.array_ready = rdy[0];
  assign if1.array_ready = rdy[1];

  systolic_feeder #(
    .WIDTH_left(8), .WIDTH_up(8), .Mritx_M(3), .Mritx_N(3), .Mritx_L(3),
    .Mritx_LOG2_size(10)
  ) dut0 (
    .clk(clk), .rst(rst[0]),
    .a_wr_en(a_en[0]), .a_wr_addr(a_addr[0]), .a_wr_data(a_data[0]),
    .b_wr_en(b_en[0]), .b_wr_addr(b_addr[0]), .b_wr_data(b_data[0]),
    .start(start[0]), .busy(busy0), .done(done0),
`ifdef SYSTOLIC_FEEDER_WR_ERR_EN
    .wr_err(err0),
`endif
    .arr(if0)
  );

  systolic_feeder #(
    .WIDTH_left(8), .WIDTH_up(8), .Mritx_M(2), .Mritx_N(4), .Mritx_L(1),
    .Mritx_LOG2_size(10)
  ) dut1 (
    .clk(clk), .rst(rst[1]),
    .a_wr_en(a_en[1]), .a_wr_addr(a_addr[1]), .a_wr_data(a_data[1]),
    .b_wr_en(b_en[1]), .b_wr_addr(b_addr[1]), .b_wr_data(b_data[1]),
    .start(start[1]), .busy(busy1), .done(done1),
`ifdef SYSTOLIC_FEEDER_WR_ERR_EN
    .wr_err(err1),
`endif
    .arr(if1)
  );

  assign obs_busy[0]  = busy0;
  assign obs_busy[1]  = busy1;
  assign obs_done[0]  = done0;
  assign obs_done[1]  = done1;
  assign obs_valid[0] = if0.valid;
  assign obs_valid[1] = if1.valid;
  assign obs_left[0]  = 32'(if0.left);
  assign obs_left[1]  = 32'(if1.left);
  assign obs_up[0]    = 32'(if0.up);
  assign obs_up[1]    = 32'(if1.up);

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h, expected %h (t=%0t)", name, d, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          dim_m [2];
  int          dim_n [2];
  int          dim_l [2];
  logic [7:0]  a_mdl [2][16];
  logic [7:0]  b_mdl [2][16];
  logic [31:0] bl    [2][8];
  logic [31:0] bu    [2][8];
  int          ph    [2];
  int          pos   [2];
  int          cnt   [2];
  logic        seen_low [2];
  logic        e_valid [2];
  logic        e_busy  [2];
  logic        e_done  [2];
  logic        e_err   [2];
  logic [31:0] e_left  [2];
  logic [31:0] e_up    [2];
  logic        chk_en = 1'b0;

  task automatic emit(input int d, input int b);
    e_valid[d] = 1'b1;
    e_left[d]  = bl[d][b];
    e_up[d]    = bu[d][b];
  endtask

  task automatic model_step(input int d);
    int ad, bd, f, ai, bi;
    logic offend, acc;
    logic [31:0] l, u;
    ad = dim_m[d] * dim_n[d];
    bd = dim_n[d] * dim_l[d];
    f  = ((dim_m[d] > dim_l[d]) ? dim_m[d] : dim_l[d]) - 1;
    ai = int'(a_addr[d]);
    bi = int'(b_addr[d]);
    offend = (a_en[d] && (ph[d] != PhIdle || ai >= ad)) ||
             (b_en[d] && (ph[d] != PhIdle || bi >= bd));
    if (ph[d] == PhIdle && a_en[d] && ai < ad) a_mdl[d][ai] = a_data[d];
    if (ph[d] == PhIdle && b_en[d] && bi < bd) b_mdl[d][bi] = b_data[d];
    e_done[d] = 1'b0;
    if (rst[d]) begin
      ph[d] = PhIdle; e_valid[d] = 1'b0; e_busy[d] = 1'b0; e_err[d] = 1'b0;
      e_left[d] = '0; e_up[d] = '0;
      return;
    end
    acc = 1'b0;
    case (ph[d])
      PhIdle: if (start[d]) begin
        acc = 1'b1;
        for (int k = 0; k < dim_n[d]; k++) begin
          l = '0; u = '0;
          for (int i = 0; i < dim_m[d]; i++) l[8*i +: 8] = a_mdl[d][i*dim_n[d]+k];
          for (int j = 0; j < dim_l[d]; j++) u[8*j +: 8] = b_mdl[d][k*dim_l[d]+j];
          bl[d][k] = l; bu[d][k] = u;
        end
        for (int z = 0; z < f; z++) begin
          bl[d][dim_n[d]+z] = '0; bu[d][dim_n[d]+z] = '0;
        end
        cnt[d] = dim_n[d] + f;
        ph[d] = PhWaitRdy; e_busy[d] = 1'b1;
      end
      PhWaitRdy: if (rdy[d]) begin
        emit(d, 0); pos[d] = 1; ph[d] = PhStream;
      end
      PhStream: begin
        if (pos[d] < cnt[d]) begin
          emit(d, pos[d]); pos[d]++;
        end else begin
          e_valid[d] = 1'b0; e_left[d] = '0; e_up[d] = '0;
          ph[d] = PhWaitDone; seen_low[d] = 1'b0;
        end
      end
      PhWaitDone: begin
        if (!rdy[d]) seen_low[d] = 1'b1;
        else if (seen_low[d]) begin
          ph[d] = PhIdle; e_busy[d] = 1'b0; e_done[d] = 1'b1;
        end
      end
      default: ph[d] = PhIdle;
    endcase
    if (acc) e_err[d] = 1'b0;
    if (offend) e_err[d] = 1'b1;
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
  end

  // ---------------- compare process + beat capture ----------------
  logic [31:0] cap_l [2][8];
  logic [31:0] cap_u [2][8];
  int          vcnt  [2];
  int          done_cnt [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (chk_en) begin
        chk("busy", d, 32'(obs_busy[d]), 32'(e_busy[d]));
        chk("done", d, 32'(obs_done[d]), 32'(e_done[d]));
        chk("valid", d, 32'(obs_valid[d]), 32'(e_valid[d]));
        if (e_valid[d]) begin
          chk("left", d, obs_left[d], e_left[d]);
          chk("up", d, obs_up[d], e_up[d]);
        end
`ifdef SYSTOLIC_FEEDER_WR_ERR_EN
        chk("wr_err", d, 32'(obs_err[d]), 32'(e_err[d]));
`endif
        if (obs_valid[d] === 1'b1 && vcnt[d] < 8) begin
          cap_l[d][vcnt[d]] = obs_left[d];
          cap_u[d][vcnt[d]] = obs_up[d];
          vcnt[d]++;
        end
        if (obs_done[d] === 1'b1) done_cnt[d]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input bit is_b, input int addr, input int data);
    if (is_b) begin
      b_en[d] = 1'b1; b_addr[d] = 10'(addr); b_data[d] = 8'(data);
    end else begin
      a_en[d] = 1'b1; a_addr[d] = 10'(addr); a_data[d] = 8'(data);
    end
    tick();
    a_en[d] = 1'b0; b_en[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (obs_done[d] === 1'b1) break;
      tick();
    end
    chk("done_seen", d, 32'(obs_done[d]), 32'd1);
  endtask

  // One full pass; sw_addr >= 0 lands an A write in the start cycle; mid puts a
  // write and a stray start in the middle of the pass.
  task automatic run_pass(input int d, input int pre_low, input bit mid,
                          input int sw_addr, input int sw_data, input int exp_beats);
    int dc;
    dc = done_cnt[d];
    vcnt[d] = 0;
    rdy[d] = 1'b0;
    start[d] = 1'b1;
    if (sw_addr >= 0) begin
      a_en[d] = 1'b1; a_addr[d] = 10'(sw_addr); a_data[d] = 8'(sw_data);
    end
    tick();
    start[d] = 1'b0; a_en[d] = 1'b0;
    chk("busy_after_start", d, 32'(obs_busy[d]), 32'd1);
    repeat (pre_low) tick();
    chk("no_beat_before_ready", d, 32'(obs_valid[d]), 32'd0);
    rdy[d] = 1'b1;
    tick();
    chk("first_beat", d, 32'(obs_valid[d]), 32'd1);
    if (mid) wr(d, 1'b0, 0, 8'h55);
    else tick();
    rdy[d] = 1'b0;
    repeat (3) tick();
    if (mid) start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    repeat (6) tick();
    rdy[d] = 1'b1;
    wait_done(d, 20);
    tick();
    chk("busy_after_done", d, 32'(obs_busy[d]), 32'd0);
    chk("valid_beats", d, 32'(vcnt[d]), 32'(exp_beats));
    chk("done_pulses", d, 32'(done_cnt[d] - dc), 32'd1);
  endtask

  task automatic check_identity_pass();
    chk("b0_left", 0, cap_l[0][0], 32'h000001);
    chk("b0_up",   0, cap_u[0][0], 32'h030201);
    chk("b2_left", 0, cap_l[0][2], 32'h010000);
    chk("b2_up",   0, cap_u[0][2], 32'h090807);
    chk("b4_flush", 0, cap_l[0][4] | cap_u[0][4], 32'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    dim_m[0] = 3; dim_n[0] = 3; dim_l[0] = 3;
    dim_m[1] = 2; dim_n[1] = 4; dim_l[1] = 1;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; a_en[d] = 1'b0; a_addr[d] = '0; a_data[d] = '0;
      b_en[d] = 1'b0; b_addr[d] = '0; b_data[d] = '0; start[d] = 1'b0; rdy[d] = 1'b0;
      vcnt[d] = 0; done_cnt[d] = 0; ph[d] = PhIdle; pos[d] = 0; cnt[d] = 0;
      seen_low[d] = 1'b0;
      for (int e = 0; e < 16; e++) begin
        a_mdl[d][e] = '0; b_mdl[d][e] = '0;
      end
    end
    tick();
    chk_en = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", d, 32'(obs_valid[d]), 32'd0);
      chk("rst_busy",  d, 32'(obs_busy[d]),  32'd0);
      chk("rst_done",  d, 32'(obs_done[d]),  32'd0);
      chk("rst_left",  d, obs_left[d], 32'd0);
      chk("rst_up",    d, obs_up[d],   32'd0);
      rst[d] = 1'b0;
    end

    // dut0: identity A, B = 1..9 row-major; one out-of-range write.
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) begin
        wr(0, 1'b0, i * 3 + k, (i == k) ? 1 : 0);
        wr(0, 1'b1, i * 3 + k, i * 3 + k + 1);
      end
    wr(0, 1'b0, 9, 8'hEE);

    run_pass(0, 0, 1'b0, -1, 0, 5);
    check_identity_pass();

    run_pass(0, 4, 1'b0, -1, 0, 5);
    check_identity_pass();

    // Write and stray start mid-pass: both must be dropped.
    run_pass(0, 0, 1'b1, -1, 0, 5);
    check_identity_pass();
`ifdef SYSTOLIC_FEEDER_WR_ERR_EN
    chk("wr_err_sticky", 0, 32'(obs_err[0]), 32'd1);
`endif
    run_pass(0, 1, 1'b0, -1, 0, 5);
    chk("old_a00_kept", 0, cap_l[0][0], 32'h000001);

    // Reset at beat 1, then replay.
    vcnt[0] = 0;
    rdy[0] = 1'b1;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    tick();
    chk("beat1_left", 0, obs_left[0], 32'h000100);
    chk("beat1_up",   0, obs_up[0],   32'h060504);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("rst_mid_valid", 0, 32'(obs_valid[0]), 32'd0);
    chk("rst_mid_busy",  0, 32'(obs_busy[0]),  32'd0);
    run_pass(0, 0, 1'b0, -1, 0, 5);
    check_identity_pass();

    // Same-cycle write + start: A[1][1] = 0x77 shows in beat 1.
    run_pass(0, 0, 1'b0, 4, 8'h77, 5);
    chk("sw_b1_left", 0, cap_l[0][1], 32'h007700);
    chk("sw_b0_left", 0, cap_l[0][0], 32'h000001);

    // dut1: M=2, N=4, L=1; A addr 8 is out of range.
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) wr(1, 1'b0, i * 4 + k, i * 16 + k + 1);
    for (int k = 0; k < 4; k++) wr(1, 1'b1, k, 8'hA0 + k);
    wr(1, 1'b0, 8, 8'hEE);
    run_pass(1, 2, 1'b0, -1, 0, 5);
    chk("d1_b0_left", 1, cap_l[1][0], 32'h1101);
    chk("d1_b0_up",   1, cap_u[1][0], 32'hA0);
    chk("d1_b3_left", 1, cap_l[1][3], 32'h1404);
    chk("d1_b3_up",   1, cap_u[1][3], 32'hA3);
    chk("d1_b4_flush", 1, cap_l[1][4] | cap_u[1][4], 32'h0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Operand feeder for the systolic matrix multiplier: buffers matrix A (M×N) and matrix B (N×L), then streams them into the array's `left`/`up` inputs under the array's valid/ready protocol. It is the transmitting end of the array's input interface. The array owns skewing through its internal shift registers, so the feeder emits unskewed beats. Each beat k carries column k of A and row k of B, followed by zero-data flush beats that drain those shift registers.

## Interface
Parameters:
- `WIDTH_left`, 8, width of one A element
- `WIDTH_up`, 8, width of one B element
- `Mritx_M`, 3, rows of A (array rows)
- `Mritx_N`, 3, inner dimension
- `Mritx_L`, 3, columns of B (array columns)
- `Mritx_LOG2_size`, 10, counter and address width

Ports:
- `clk` in 1: single clock
- `rst` in 1: reset, synchronous, active-high
- `a_wr_en` in 1: A element write strobe
- `a_wr_addr` in `Mritx_LOG2_size`: flat index i*N+k
- `a_wr_data` in `WIDTH_left`: A[i][k]
- `b_wr_en` in 1: B element write strobe
- `b_wr_addr` in `Mritx_LOG2_size`: flat index k*L+j
- `b_wr_data` in `WIDTH_up`: B[k][j]
- `start` in 1: request one multiply pass
- `busy` out 1: pass in progress
- `done` out 1: one-cycle pulse at pass completion
- `array_ready` in 1: the array's `ready`
- `valid` out 1: to the array's `valid`
- `left` out `Mritx_M*WIDTH_left`: slice i = A[i][k]
- `up` out `Mritx_L*WIDTH_up`: slice j = B[k][j]

## Operation
- States: IDLE, WAIT_RDY, STREAM, FLUSH, WAIT_DONE.
- IDLE:
  - Writes are accepted; addresses ≥ M*N (A) or ≥ N*L (B) are ignored.
  - `start`=1 → WAIT_RDY.
- WAIT_RDY: `array_ready`=1 → STREAM with k=0.
- STREAM:
  - `valid`=1, `left`/`up` = beat k.
  - k increments each cycle; after beat N-1 → FLUSH.
- FLUSH:
  - `valid`=1, `left`=`up`=0 for F = max(M,L)-1 cycles.
  - If F=0, skip directly to WAIT_DONE.
- WAIT_DONE:
  - `valid`=0.
  - Requires `array_ready` to be seen low, then high (the array's return to idle).
  - On that rising edge → IDLE with `done`=1.
- `busy`=1 in every state except IDLE.
- `start` while busy: ignored.
- Writes while busy: dropped; buffer contents are frozen for the whole pass.
- Same-cycle write and `start` in IDLE: the write lands and is visible to the pass.
- Buffers are not cleared by `rst` and retain their contents across passes, so a repeat `start` reuses the same operands.

## Timing
- Reset values: `valid`=0, `left`=0, `up`=0, `busy`=0, `done`=0; state IDLE; k=0.
- All outputs are registered.
- `start` sampled high in IDLE at cycle t → `busy`=1 at t+1.
- `array_ready` high in WAIT_RDY at cycle t → first beat (`valid`=1, k=0) at t+1.
- `valid` stays high for exactly N+F consecutive cycles; there are no gaps.
- `array_ready` is ignored during STREAM and FLUSH.
- `done` is asserted for one cycle in the same cycle that `busy` falls.
- `rst` mid-pass: outputs return to reset values next cycle and the state returns to IDLE; buffer contents are kept.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- `SYSTOLIC_FEEDER_WR_ERR_EN` defined:
  - Adds output `wr_err` (1 bit, reset 0).
  - Sticky; set on any `a_wr_en`/`b_wr_en` while busy or with an out-of-range address.
  - Cleared when a `start` is accepted.
- Undefined: no `wr_err` port; offending writes are silently dropped.

## Structure
- Package `systolic_pkg`: state encoding type; localparams for F = max(M,L)-1, A depth M*N and B depth N*L.
- Sub-module `feeder_bank`:
  - Parameterized rows × cols × width register file.
  - One write port, plus a combinational read of a full row-or-column slice selected by k.
  - Instantiated twice: A read by column, B read by row.
- Top: FSM, beat counter k, flush counter, `array_ready` edge tracking, output registers.

## Test plan
- Identity A, B = 1..9 row-major, M=N=L=3, WIDTH=8, `array_ready`=1:
  - Beat 0 → `left`={0,0,1}, `up`={3,2,1} (slice 2..0).
  - Beat 2 → `left`={1,0,0}, `up`={9,8,7}.
  - Then two zero beats; `valid` high for exactly 5 cycles.
- Hold `array_ready`=0 for 4 cycles after `start` → `valid` stays 0; first beat comes 1 cycle after `array_ready` rises.
- Completion: drive `array_ready` 1→0 (2 cycles after first beat) → 0 for 10 cycles → 1; `done` pulses once on the rising edge, with `busy` falling in that same cycle.
- Write A[0][0]=0x55 during STREAM → the current pass is unchanged; a second pass still shows the old value; with `SYSTOLIC_FEEDER_WR_ERR_EN`, `wr_err`=1 until the next `start`.
- Assert `rst` in STREAM at beat 1 → next cycle `valid`=0, `busy`=0; a subsequent `start` replays the identical beat sequence.
- M=2, N=4, L=1 → 4 data beats plus 1 flush beat; an out-of-range address write (A addr 8) is ignored.
